// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel plus the word-memory strobe bus of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid & req_ready; resp_valid is a one-cycle pulse that is never back-pressured.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport slave (
        input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata, Read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address, Write_data
    );

    modport master (
        output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata, Read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, Address, Write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a 256 x 32-bit word memory with level strobes.
// Sub-word stores are done as read, merge, write; bad requests are answered without a memory access.
module load_store_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus,
    output logic [2:0]         dbg_state
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_store_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic [1:0]      lane_q;
    logic [15:0]     wdata_q;
    logic [31:0]     rd_word;

    // Only the word index bits of the byte address reach memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:10];

    assign dbg_state = state;

    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lo);
        req_is_bad = (size == 2'b11) ||
                     (size == 2'b01 && lo[0]) ||
                     (size == 2'b10 && lo != 2'b00);
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extend = {{24{sgn & b[7]}}, b};
            2'b01:   extend = {{16{sgn & h[15]}}, h};
            default: extend = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{lane, 3'b000} +: 8] = wd[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = wd;
        merge = m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            is_store_q     <= 1'b0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= '0;
            rd_word        <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.MemRead    <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.Address    <= '0;
            bus.Write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        is_store_q    <= bus.req_is_store;
                        size_q        <= bus.req_size;
                        signed_q      <= bus.req_signed;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata[15:0];
                        bus.Address   <= {24'b0, bus.req_addr[9:2]};
                        cnt           <= '0;
                        if (req_is_bad(bus.req_size, bus.req_addr[1:0])) begin
                            state          <= ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (bus.req_is_store && bus.req_size == 2'b10) begin
                            state          <= WR;
                            bus.MemWrite   <= 1'b1;
                            bus.Write_data <= bus.req_wdata;
                        end else begin
                            state       <= RD;
                            bus.MemRead <= 1'b1;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                RD: begin
                    if (cnt == LAST) begin
                        bus.MemRead <= 1'b0;
                        cnt         <= '0;
                        if (is_store_q) begin
                            rd_word <= bus.Read_data;
                            state   <= MERGE;
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b0;
                            bus.resp_rdata <= extend(bus.Read_data, size_q, signed_q, lane_q);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The idle strobe cycle here separates the read from the write.
                MERGE: begin
                    bus.Write_data <= merge(rd_word, wdata_q, size_q, lane_q);
                    bus.MemWrite   <= 1'b1;
                    state          <= WR;
                end
                WR: begin
                    if (cnt == LAST) begin
                        bus.MemWrite   <= 1'b0;
                        cnt            <= '0;
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP, ERR: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state          <= IDLE;
                    bus.MemRead    <= 1'b0;
                    bus.MemWrite   <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT 1 and 3) each on a behavioural word memory,
// driven with directed and random requests and checked against a byte-level reference model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    int          sel = 0;

    load_store_unit_if bus1();
    load_store_unit_if bus3();
    logic [2:0] dbg1, dbg3;

    load_store_unit #(.MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave), .dbg_state(dbg1));
    load_store_unit #(.MEM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave), .dbg_state(dbg3));

    assign bus1.req_valid    = req_valid && (sel == 0);
    assign bus3.req_valid    = req_valid && (sel == 1);
    assign bus1.req_is_store = req_is_store;
    assign bus3.req_is_store = req_is_store;
    assign bus1.req_size     = req_size;
    assign bus3.req_size     = req_size;
    assign bus1.req_signed   = req_signed;
    assign bus3.req_signed   = req_signed;
    assign bus1.req_addr     = req_addr;
    assign bus3.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus3.req_wdata    = req_wdata;

    // Behavioural data memories, one per instance.
    logic [31:0] mem [2][256];
    logic [31:0] ref_mem [2][256];
    assign bus1.Read_data = mem[0][bus1.Address[7:0]];
    assign bus3.Read_data = mem[1][bus3.Address[7:0]];
    always @(posedge clk) begin
        if (bus1.MemWrite) mem[0][bus1.Address[7:0]] <= bus1.Write_data;
        if (bus3.MemWrite) mem[1][bus3.Address[7:0]] <= bus3.Write_data;
    end

    logic        m_ready, m_rv, m_err, m_rd, m_wr;
    logic [31:0] m_rdata, m_addr, m_wdata;
    assign m_ready = (sel == 1) ? bus3.req_ready  : bus1.req_ready;
    assign m_rv    = (sel == 1) ? bus3.resp_valid : bus1.resp_valid;
    assign m_err   = (sel == 1) ? bus3.resp_err   : bus1.resp_err;
    assign m_rd    = (sel == 1) ? bus3.MemRead    : bus1.MemRead;
    assign m_wr    = (sel == 1) ? bus3.MemWrite   : bus1.MemWrite;
    assign m_rdata = (sel == 1) ? bus3.resp_rdata : bus1.resp_rdata;
    assign m_addr  = (sel == 1) ? bus3.Address    : bus1.Address;
    assign m_wdata = (sel == 1) ? bus3.Write_data : bus1.Write_data;

    logic [31:0] exp_q[$];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v = (w >> sh) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            v = (w >> sh) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask, data;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        data = wd << sh;
        return (w & ~mask) | (data & mask);
    endfunction

    task automatic do_req(input int s, input bit st, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int lat_l, exp_lat, c, w, rd_n, wr_n, pulses, overlap, bad_addr, bad_wd, bad_rdy, extra;
        bit err, prev, got;
        logic [31:0] old_w, new_w, exp_rd, exp_addr;
        lat_l = (s == 1) ? 3 : 1;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        old_w = ref_mem[s][a[9:2]];
        new_w = st ? ref_store(old_w, a, sz, wd) : old_w;
        exp_rd = (err || st) ? 32'h0 : ref_load(old_w, a, sz, sg);
        exp_q.push_back(exp_rd);
        exp_lat = err ? 1 : (st && sz != 2'b10) ? 2 * lat_l + 2 : lat_l + 1;
        exp_addr = {24'b0, a[9:2]};

        @(negedge clk);
        sel = s;
        req_valid = 1'b1;
        req_is_store = st;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        w = 0;
        while (!m_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(w < 20), 32'd1);
        if (w >= 20) begin
            req_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        c = 1; got = 0; prev = 0;
        rd_n = 0; wr_n = 0; pulses = 0; overlap = 0; bad_addr = 0; bad_wd = 0; bad_rdy = 0;
        while (c <= 40 && !got) begin
            if (m_rd) rd_n++;
            if (m_wr) wr_n++;
            if (m_rd && m_wr) overlap++;
            if ((m_rd || m_wr) && !prev) pulses++;
            prev = m_rd || m_wr;
            if ((m_rd || m_wr) && m_addr !== exp_addr) bad_addr++;
            if (m_wr && m_wdata !== new_w) bad_wd++;
            if (m_ready) bad_rdy++;
            if (m_rv) got = 1;
            else begin
                c++;
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        check("latency", got ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_lat));
        check("resp_err", {31'b0, got ? m_err : 1'bx}, {31'b0, err});
        check("resp_rdata", m_rdata, exp_q.pop_front());
        check("read_cycles", 32'(rd_n), (err || (st && sz == 2'b10)) ? 32'd0 : 32'(lat_l));
        check("write_cycles", 32'(wr_n), (st && !err) ? 32'(lat_l) : 32'd0);
        check("strobe_pulses", 32'(pulses), err ? 32'd0 : (st && sz != 2'b10) ? 32'd2 : 32'd1);
        check("strobe_overlap", 32'(overlap), 32'd0);
        check("address_bad", 32'(bad_addr), 32'd0);
        check("wdata_bad", 32'(bad_wd), 32'd0);
        check("ready_busy", 32'(bad_rdy), 32'd0);
        last_rdata = m_rdata;
        if (hold) begin
            extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (m_rv) extra++;
            end
            check("no_extra_resp", 32'(extra), 32'd0);
        end
        if (st && !err) ref_mem[s][a[9:2]] = new_w;
    endtask

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int rv_n;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                v = $urandom;
                mem[k][i] = v;
                ref_mem[k][i] = v;
            end
        end
        for (int k = 0; k < 2; k++) begin
            mem[k][19] = 32'h5555_5555;     ref_mem[k][19] = 32'h5555_5555;
            mem[k][200] = 32'hFEDC_BA98;    ref_mem[k][200] = 32'hFEDC_BA98;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus1.req_ready | bus3.req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, bus1.resp_valid | bus3.resp_valid}, 32'd0);
        check("rst_strobes", {30'b0, bus1.MemRead | bus3.MemRead, bus1.MemWrite | bus3.MemWrite}, 32'd0);
        check("rst_address", bus1.Address | bus3.Address, 32'd0);
        check("rst_write_data", bus1.Write_data | bus3.Write_data, 32'd0);
        check("rst_rdata", bus1.resp_rdata | bus3.resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, bus1.req_ready & bus3.req_ready}, 32'd1);

        // Directed cases, MEM_LAT = 1.
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_004C, 32'h0, 1'b0);
        check("ld_4c_const", last_rdata, 32'h5555_5555);
        do_req(0, 1'b0, 2'b00, 1'b1, 32'h0000_0320, 32'h0, 1'b0);
        check("lb_320_const", last_rdata, 32'hFFFF_FF98);
        do_req(0, 1'b0, 2'b00, 1'b0, 32'h0000_0323, 32'h0, 1'b0);
        check("lbu_323_const", last_rdata, 32'h0000_00FE);
        do_req(0, 1'b0, 2'b01, 1'b1, 32'h0000_0322, 32'h0, 1'b0);
        check("lh_322_const", last_rdata, 32'hFFFF_FEDC);
        do_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_0322, 32'h0000_1234, 1'b0);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0320, 32'h0, 1'b0);
        check("merge_const", last_rdata, 32'h1234_BA98);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_004E, 32'h0, 1'b0);
        do_req(0, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // MEM_LAT = 3, with req_valid held high while busy.
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 1'b1);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("lat3_ld_const", last_rdata, 32'hA5A5_A5A5);
        do_req(1, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_003C, 1'b0);

        // Random traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            do_req((n < 40) ? 0 : 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), {22'($urandom), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                   $urandom, 1'b0);
        end

        // Reset during the read phase of a load.
        @(negedge clk);
        sel = 1;
        req_is_store = 1'b0;
        req_size = 2'b10;
        req_addr = 32'h0000_004C;
        req_valid = 1'b1;
        while (!m_ready) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rst_pre_rd", {31'b0, m_rd}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rd", {31'b0, m_rd}, 32'd0);
        check("mid_rst_rv", {31'b0, m_rv}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, m_ready}, 32'd1);
        rv_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_rv) rv_n++;
            @(negedge clk);
        end
        check("mid_rst_no_resp", 32'(rv_n), 32'd0);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h0000_004C, 32'h0, 1'b0);
        check("post_rst_ld_const", last_rdata, 32'h5555_5555);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the execute stage and the word-organised data memory (256 × 32-bit, word index on `Address[7:0]`, level-sensitive `MemRead`/`MemWrite` strobes). It accepts one byte-addressed load or store per handshake and generates the strobe sequence for it, including read-modify-write for sub-word stores. It sign- or zero-extends load data and returns a single-cycle response to the pipeline. Misaligned or malformed requests are rejected without touching memory.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles a strobe is held before the access completes; legal values ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load data; ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`; misaligned or illegal size.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `Address` out 32: `{24'b0, req_addr[9:2]}`, registered at accept.
- `Write_data` out 32: registered store word.
- `Read_data` in 32: memory read data.

## Operation
- Accept occurs on an edge where `req_valid & req_ready`. All request fields are registered at accept. While busy, `req_ready`=0 and any request is ignored.
- Error check at accept: the request is an error if `req_size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0. An error request goes to ERR, which raises no strobes.
- States and transitions:
  - IDLE: accepts a request.
  - RD: `MemRead`=1 for `MEM_LAT` cycles; captures `Read_data` on the last edge.
  - MERGE: strobes low for 1 cycle; merges the store lanes into the captured word and registers the result to `Write_data`.
  - WR: `MemWrite`=1 for `MEM_LAT` cycles.
  - RESP: strobes low; `resp_valid`=1.
  - ERR: `resp_valid`=1, `resp_err`=1.
- Paths through the states:
  - Load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP. `Write_data`=`req_wdata`.
  - Byte/half store: IDLE→RD→MERGE→WR→RESP.
  - Error: IDLE→ERR→IDLE.
  - RESP and ERR both return to IDLE.
- `MemRead` and `MemWrite` are never high together. Both are low for at least one cycle between consecutive accesses, which guarantees the memory sees a fresh strobe event.
- Lane handling is little-endian. Byte lane is `addr[1:0]` (bits 8·lane+7 : 8·lane). Half lane is `addr[1]` (bits 16·h+15 : 16·h).
- Load extension: byte/half results are zero- or sign-extended to 32 bits per `req_signed`. Word loads pass through unchanged.
- Sub-word store merge: only the addressed lane is replaced, using `req_wdata[7:0]` or `req_wdata[15:0]`. All other bits keep the value read.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE; `req_ready`, `resp_valid`, `resp_err`, `MemRead`, `MemWrite`=0; `Address`, `Write_data`, `resp_rdata`=0. `req_ready`=1 in the first cycle after reset releases.
- Reset mid-operation: any in-flight access is abandoned. Strobes drop at that edge and no response is produced.
- Latencies counted from the accept edge E0, with L=`MEM_LAT`:
  - Load: `resp_valid` high in cycle E0+L+1.
  - Word store: `resp_valid` high in cycle E0+L+1.
  - Sub-word store: `resp_valid` high in cycle E0+2L+2.
  - Error: `resp_valid` high in cycle E0+1.
- `req_ready` rises in the cycle after `resp_valid`. Back-to-back loads with L=1 therefore issue one per 3 cycles.
- `Address` is stable from E0 until the next accept. `Write_data` is stable throughout WR.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1 and are held until the next response.

## Test plan
- Memory preset: word 19 = 0x55555555, word 200 = 0xFEDCBA98.
- Word load at 0x4C, L=1 → `MemRead` high exactly 1 cycle with `Address`=0x13; `resp_valid` in cycle E0+2 with `resp_rdata`=0x55555555; `resp_err`=0.
- Byte loads at word 200: signed load at 0x320 → 0xFFFFFF98; unsigned load at 0x323 → 0x000000FE; signed half load at 0x322 → 0xFFFFFEDC.
- Half store 0x00001234 to 0x322, then word load at 0x320 → sequence RD, MERGE, WR (1 cycle each, strobes never overlap, gap cycle between them); load returns 0x1234BA98.
- Misaligned word load at 0x4E, then `req_size`=11 at 0x10 → each gives `resp_valid`=1, `resp_err`=1 in cycle E0+1, `resp_rdata`=0, `MemRead`/`MemWrite` never asserted.
- MEM_LAT=3: word store 0xA5A5A5A5 to 0x10, then load 0x10 → `MemWrite` high 3 cycles; read returns 0xA5A5A5A5 at E0+4. A `req_valid` held high while busy is not accepted.
- Assert `rst_n`=0 during RD of a load → `MemRead`=0 and no `resp_valid` after that edge; `req_ready`=1 one cycle after release; the next load completes normally.
